// File: rtl/dram_rptr_pkg.sv
// Shared constants for the DDR read/command pointer pipeline: inactive command
// levels, reset values and the legal parameter ranges.
package dram_rptr_pkg;

  localparam logic CMD_L_INACTIVE  = 1'b1;
  localparam logic DRIVE_INACTIVE  = 1'b0;
  localparam logic RST_CKE         = 1'b0;
  localparam logic RST_CLK_ENABLE  = 1'b0;
  localparam logic RST_PAD_CLK_INV = 1'b0;
  localparam logic RST_PAD_ENABLE  = 1'b0;
  localparam logic RST_CH_DISABLED = 1'b1;
  localparam logic RST_VALID       = 1'b0;

  localparam int STAGES_MIN = 1;
  localparam int STAGES_MAX = 4;
  localparam int BURST_MIN  = 2;
  localparam int BURST_MAX  = 8;

  function automatic bit stages_legal(input int n);
    return (n >= STAGES_MIN) && (n <= STAGES_MAX);
  endfunction

  function automatic bit burst_legal(input int n);
    return (n >= BURST_MIN) && (n <= BURST_MAX) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/dram_rptr_stage.sv
// One pipeline register with a parametrised reset value and optional load enable.
module dram_rptr_stage #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0,
  parameter bit           USE_EN  = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] q_r;

  // Stage register: reset to RST_VAL, otherwise load (gated by en when enabled)
  always_ff @(posedge clk) begin
    if (rst) begin
      q_r <= RST_VAL;
    end else if (!USE_EN || en) begin
      q_r <= d;
    end else begin
      q_r <= q_r;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/dram_ddr_rptr_pipe.sv
// Retiming pipeline for DDR pad command/write signals and read-return data,
// with a read-burst beat counter and sticky short-burst detection.
module dram_ddr_rptr_pipe
  import dram_rptr_pkg::*;
#(
  parameter int DATA_W     = 256,
  parameter int ECC_W      = 32,
  parameter int WDATA_W    = 288,
  parameter int ADDR_W     = 15,
  parameter int BANK_W     = 3,
  parameter int CS_W       = 4,
  parameter int PTR_W      = 5,
  parameter int CMD_STAGES = 2,
  parameter int RD_STAGES  = 2,
  parameter int BURST_LEN  = 4,
  localparam int BEAT_W    = $clog2(BURST_LEN)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               dram_io_cas_l,
  input  logic               dram_io_ras_l,
  input  logic               dram_io_write_en_l,
  input  logic               dram_io_cke,
  input  logic               dram_io_clk_enable,
  input  logic               dram_io_drive_data,
  input  logic               dram_io_drive_enable,
  input  logic               dram_io_pad_clk_inv,
  input  logic               dram_io_pad_enable,
  input  logic               dram_io_channel_disabled,
  input  logic [ADDR_W-1:0]  dram_io_addr,
  input  logic [BANK_W-1:0]  dram_io_bank,
  input  logic [CS_W-1:0]    dram_io_cs_l,
  input  logic [WDATA_W-1:0] dram_io_data_out,
  input  logic [PTR_W-1:0]   dram_io_ptr_clk_inv,
  output logic               dram_io_cas_l_buf,
  output logic               dram_io_ras_l_buf,
  output logic               dram_io_write_en_l_buf,
  output logic               dram_io_cke_buf,
  output logic               dram_io_clk_enable_buf,
  output logic               dram_io_drive_data_buf,
  output logic               dram_io_drive_enable_buf,
  output logic               dram_io_pad_clk_inv_buf,
  output logic               dram_io_pad_enable_buf,
  output logic               dram_io_channel_disabled_buf,
  output logic [ADDR_W-1:0]  dram_io_addr_buf,
  output logic [BANK_W-1:0]  dram_io_bank_buf,
  output logic [CS_W-1:0]    dram_io_cs_l_buf,
  output logic [WDATA_W-1:0] dram_io_data_out_buf,
  output logic [PTR_W-1:0]   dram_io_ptr_clk_inv_buf,
  input  logic               io_dram_data_valid,
  input  logic [DATA_W-1:0]  io_dram_data_in,
  input  logic [ECC_W-1:0]   io_dram_ecc_in,
  output logic               io_dram_data_valid_buf,
  output logic [DATA_W-1:0]  io_dram_data_in_buf,
  output logic [ECC_W-1:0]   io_dram_ecc_in_buf,
  output logic               io_dram_burst_last_buf,
  output logic [BEAT_W-1:0]  rd_beat_cnt,
  input  logic               burst_err_clr,
  output logic               burst_err
);

  if (!stages_legal(CMD_STAGES) || !stages_legal(RD_STAGES) || !burst_legal(BURST_LEN)) begin : g_bad_param
    $error("dram_ddr_rptr_pipe: illegal CMD_STAGES, RD_STAGES or BURST_LEN");
  end

  localparam int CMD_W = 10 + ADDR_W + BANK_W + CS_W + WDATA_W + PTR_W;
  localparam int RD_W  = DATA_W + ECC_W;

  localparam logic [CMD_W-1:0] CMD_RST = {
    CMD_L_INACTIVE, CMD_L_INACTIVE, CMD_L_INACTIVE,
    RST_CKE, RST_CLK_ENABLE, DRIVE_INACTIVE, DRIVE_INACTIVE,
    RST_PAD_CLK_INV, RST_PAD_ENABLE, RST_CH_DISABLED,
    {ADDR_W{1'b0}}, {BANK_W{1'b0}}, {CS_W{1'b1}}, {WDATA_W{1'b0}}, {PTR_W{1'b0}}
  };

  logic              cas_s, ras_s, we_s, drive_data_s, drive_enable_s;
  logic [CS_W-1:0]   cs_s;
  logic [CMD_W-1:0]  cmd_s [CMD_STAGES+1];
  logic              vld_s [RD_STAGES+1];
  logic [RD_W-1:0]   rd_s  [RD_STAGES+1];
  logic [BEAT_W-1:0] beat_cnt_r;
  logic              burst_err_r;

  // A disabled channel is forced to an inactive command before stage 0
  always_comb begin
    cas_s          = dram_io_cas_l;
    ras_s          = dram_io_ras_l;
    we_s           = dram_io_write_en_l;
    cs_s           = dram_io_cs_l;
    drive_data_s   = dram_io_drive_data;
    drive_enable_s = dram_io_drive_enable;
    if (dram_io_channel_disabled) begin
      cas_s          = CMD_L_INACTIVE;
      ras_s          = CMD_L_INACTIVE;
      we_s           = CMD_L_INACTIVE;
      cs_s           = {CS_W{1'b1}};
      drive_data_s   = DRIVE_INACTIVE;
      drive_enable_s = DRIVE_INACTIVE;
    end else begin
      cs_s           = dram_io_cs_l;
    end
  end

  assign cmd_s[0] = {cas_s, ras_s, we_s, dram_io_cke, dram_io_clk_enable,
                     drive_data_s, drive_enable_s, dram_io_pad_clk_inv,
                     dram_io_pad_enable, dram_io_channel_disabled,
                     dram_io_addr, dram_io_bank, cs_s, dram_io_data_out,
                     dram_io_ptr_clk_inv};

  for (genvar i = 0; i < CMD_STAGES; i++) begin : g_cmd
    dram_rptr_stage #(.W(CMD_W), .RST_VAL(CMD_RST), .USE_EN(1'b0)) u_stage (
      .clk(clk), .rst(rst), .en(1'b1), .d(cmd_s[i]), .q(cmd_s[i+1])
    );
  end

  assign {dram_io_cas_l_buf, dram_io_ras_l_buf, dram_io_write_en_l_buf,
          dram_io_cke_buf, dram_io_clk_enable_buf, dram_io_drive_data_buf,
          dram_io_drive_enable_buf, dram_io_pad_clk_inv_buf,
          dram_io_pad_enable_buf, dram_io_channel_disabled_buf,
          dram_io_addr_buf, dram_io_bank_buf, dram_io_cs_l_buf,
          dram_io_data_out_buf, dram_io_ptr_clk_inv_buf} = cmd_s[CMD_STAGES];

  assign vld_s[0] = io_dram_data_valid;
  assign rd_s[0]  = {io_dram_data_in, io_dram_ecc_in};

  // Data stage i loads only alongside the valid bit entering that stage
  for (genvar i = 0; i < RD_STAGES; i++) begin : g_rd
    dram_rptr_stage #(.W(1), .RST_VAL(RST_VALID), .USE_EN(1'b0)) u_vld (
      .clk(clk), .rst(rst), .en(1'b1), .d(vld_s[i]), .q(vld_s[i+1])
    );
    dram_rptr_stage #(.W(RD_W), .RST_VAL({RD_W{1'b0}}), .USE_EN(1'b1)) u_data (
      .clk(clk), .rst(rst), .en(vld_s[i]), .d(rd_s[i]), .q(rd_s[i+1])
    );
  end

  assign io_dram_data_valid_buf                   = vld_s[RD_STAGES];
  assign {io_dram_data_in_buf, io_dram_ecc_in_buf} = rd_s[RD_STAGES];

  // Beat counter wraps naturally since BURST_LEN is a power of two; a gap mid-burst is sticky
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt_r  <= {BEAT_W{1'b0}};
      burst_err_r <= 1'b0;
    end else if (io_dram_data_valid_buf) begin
      beat_cnt_r  <= beat_cnt_r + {{(BEAT_W-1){1'b0}}, 1'b1};
      burst_err_r <= burst_err_r && !burst_err_clr;
    end else if (beat_cnt_r != {BEAT_W{1'b0}}) begin
      beat_cnt_r  <= {BEAT_W{1'b0}};
      burst_err_r <= 1'b1;
    end else begin
      beat_cnt_r  <= beat_cnt_r;
      burst_err_r <= burst_err_r && !burst_err_clr;
    end
  end

  assign rd_beat_cnt            = beat_cnt_r;
  assign burst_err              = burst_err_r;
  assign io_dram_burst_last_buf = io_dram_data_valid_buf &&
                                  (beat_cnt_r == BEAT_W'(BURST_LEN - 1));

endmodule

// File: doc/dram_ddr_rptr_pipe.md
DRAM_DDR_RPTR_PIPE -- requirements
Module: dram_ddr_rptr_pipe

Interface
Parameters:
REQ-001 SHALL: DATA_W, default 256, read data width.
REQ-002 SHALL: ECC_W, default 32, read ECC width.
REQ-003 SHALL: WDATA_W, default 288, write data width.
REQ-004 SHALL: ADDR_W, default 15, address width.
REQ-005 SHALL: BANK_W, default 3, bank width.
REQ-006 SHALL: CS_W, default 4, chip-select width.
REQ-007 SHALL: PTR_W, default 5, pointer-clock-invert width.
REQ-008 SHALL: CMD_STAGES, default 2, legal 1..4, command/write path register stages.
REQ-009 SHALL: RD_STAGES, default 2, legal 1..4, read-return path register stages.
REQ-010 SHALL: BURST_LEN, default 4, power of two, 2..8, read beats per burst.
Ports (name, direction, width, meaning):
REQ-011 SHALL: clk in 1, single clock; rst in 1, synchronous active-high reset.
REQ-012 SHALL: dram_io_cas_l, dram_io_ras_l, dram_io_write_en_l, dram_io_cke, dram_io_clk_enable, dram_io_drive_data, dram_io_drive_enable, dram_io_pad_clk_inv, dram_io_pad_enable, dram_io_channel_disabled in 1 each; matching *_buf out 1 each.
REQ-013 SHALL: dram_io_addr in ADDR_W, dram_io_bank in BANK_W, dram_io_cs_l in CS_W, dram_io_data_out in WDATA_W, dram_io_ptr_clk_inv in PTR_W; matching *_buf outputs of the same widths.
REQ-014 SHALL: io_dram_data_valid in 1, io_dram_data_in in DATA_W, io_dram_ecc_in in ECC_W; matching *_buf outputs.
REQ-015 SHALL: io_dram_burst_last_buf out 1, final beat of a burst; rd_beat_cnt out log2(BURST_LEN), output-side beat index; burst_err out 1, sticky short-burst flag; burst_err_clr in 1, clears burst_err.

Function
REQ-016 SHALL: every command/write-path output equals its stage-0 captured value delayed exactly CMD_STAGES cycles.
REQ-017 SHALL: when dram_io_channel_disabled=1 at capture, stage 0 loads cas_l=ras_l=write_en_l=1, cs_l=all ones, drive_data=drive_enable=0; all other fields, including channel_disabled, pass unmodified.
REQ-018 SHALL: io_dram_data_valid_buf equals io_dram_data_valid delayed exactly RD_STAGES cycles.
REQ-019 SHALL: read data/ECC stage registers load only when that stage's valid is 1 and otherwise hold; data_in_buf/ecc_in_buf therefore hold the last valid beat.
REQ-020 SHALL: rd_beat_cnt increments modulo BURST_LEN on each cycle io_dram_data_valid_buf=1.
REQ-021 SHALL: io_dram_burst_last_buf=1 combinationally when io_dram_data_valid_buf=1 and rd_beat_cnt=BURST_LEN-1.
REQ-022 SHALL: when io_dram_data_valid_buf=0 and rd_beat_cnt!=0, burst_err sets to 1 next cycle and rd_beat_cnt returns to 0.
REQ-023 SHALL: burst_err clears the cycle after burst_err_clr=1; a set condition coincident with clear wins (burst_err stays 1).
REQ-024 SHALL: back-to-back bursts with no gap count continuously with no error.

Reset
REQ-025 SHALL: while rst=1 all stages load cas_l=ras_l=write_en_l=1, cs_l=all ones, cke=clk_enable=0, drive_data=drive_enable=pad_enable=0, channel_disabled=1, all buses 0, valid=0; rd_beat_cnt=0, burst_err=0.
REQ-026 SHALL: reset asserted mid-burst or mid-pipeline flushes all stages; outputs show reset values from the next edge; no burst_err is raised by the flush.
REQ-027 SHALL: after rst deasserts, the first captured input appears at outputs after CMD_STAGES/RD_STAGES cycles.

Structure
REQ-028 SHALL: inactive command constants, reset values and parameter legality ranges live in shared package dram_rptr_pkg.
REQ-029 SHALL: one sub-module dram_rptr_stage (parametrised width, reset value, optional load enable) is instantiated per stage per path.
REQ-030 SHALL: illegal parameter values are rejected at elaboration.

Verification
REQ-031 SHALL: CMD_STAGES=3, drive addr=0x1A5 at cycle 10 -> dram_io_addr_buf=0x1A5 at cycle 13 only.
REQ-032 SHALL: channel_disabled=1 with cs_l=0x0, cas_l=0 -> after CMD_STAGES, cs_l_buf=0xF, cas_l_buf=1, addr passes.
REQ-033 SHALL: four consecutive valid beats D0..D3 -> burst_last_buf on D3 output cycle, rd_beat_cnt 0,1,2,3 then 0, burst_err=0.
REQ-034 SHALL: two valid beats then valid=0 -> burst_err=1 next cycle, rd_beat_cnt=0; burst_err_clr -> 0; clr coincident with new short burst -> stays 1.
REQ-035 SHALL: rst during beat 2 of a burst -> all outputs at reset values next edge, burst_err=0; valid=0 with data toggling -> data_in_buf holds.
